retire_tracker: RTL and testbench

Tracks which pipeline slots hold real instructions between ID and EX and produces an exact per-cycle retire pulse for the instret counter in the CSR file. This removes the need for fixed pipeline-fill and branch corrections in that counter. The block also decodes read-only CSR instructions in ID and delivers the CSR-file read controls registered into EX. It sits between the IF/ID pipeline register logic and the CSR file, alongside the hazard unit.

---
 rtl/retire_tracker.sv | 123 ++++++++++++
 tb/tb_retire_tracker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/retire_tracker.sv
// retire_tracker: tracks the valid bits for the ID and EX slots and generates
// an exact per-cycle retire pulse for instret. It also decodes read-only CSR
// instructions in ID and registers the CSR-file read controls into EX.
module retire_tracker #(
  parameter int unsigned KILL_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_valid,
  input  logic                  IM_stall,
  input  logic                  DM_stall,
  input  logic                  stall,
  input  logic                  wrongBranch,
  input  logic [31:0]           id_inst,
  output logic                  ex_valid,
  output logic                  retire,
  output logic                  csr_enable,
  output logic [1:0]            csr_op,
  output logic                  illegal_csr,
  output logic [KILL_CNT_W-1:0] kill_count
);

  localparam int unsigned SUM_W = KILL_CNT_W + 1;

  localparam logic [1:0] CSR_CYCLE_LOW    = 2'd0;
  localparam logic [1:0] CSR_CYCLE_HIGH   = 2'd1;
  localparam logic [1:0] CSR_INSTRET_LOW  = 2'd2;
  localparam logic [1:0] CSR_INSTRET_HIGH = 2'd3;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_CSRRS   = 3'b010;

  logic                  r_v_id;
  logic                  r_v_ex;
  logic                  r_csr_enable;
  logic [1:0]            r_csr_op;
  logic                  r_illegal_csr;
  logic [KILL_CNT_W-1:0] r_kill_count;

  logic                  w_freeze;
  logic                  w_dec_enable;
  logic [1:0]            w_dec_op;
  logic                  w_dec_illegal;
  logic [SUM_W-1:0]      w_kill_sum;
  logic [KILL_CNT_W-1:0] w_kill_next;
  logic                  w_unused_rd;

  assign w_freeze    = IM_stall | DM_stall;
  assign w_unused_rd = ^id_inst[11:7];

  // Decode the ID instruction into CSR read controls.
  always_comb begin
    w_dec_enable  = 1'b0;
    w_dec_op      = 2'b00;
    w_dec_illegal = 1'b0;
    if (id_inst[6:0] == OPC_SYSTEM && id_inst[14:12] != 3'b000) begin
      if (id_inst[14:12] == F3_CSRRS && id_inst[19:15] == 5'd0) begin
        w_dec_enable = 1'b1;
        case (id_inst[31:20])
          12'hC00: w_dec_op = CSR_CYCLE_LOW;
          12'hC80: w_dec_op = CSR_CYCLE_HIGH;
          12'hC02: w_dec_op = CSR_INSTRET_LOW;
          12'hC82: w_dec_op = CSR_INSTRET_HIGH;
          default: begin
            w_dec_enable  = 1'b0;
            w_dec_illegal = 1'b1;
          end
        endcase
      end else begin
        w_dec_illegal = 1'b1;
      end
    end
  end

  // Saturating add of the squashed valid instructions (0, 1 or 2).
  always_comb begin
    w_kill_sum  = {1'b0, r_kill_count} + SUM_W'(r_v_id) + SUM_W'(fetch_valid);
    w_kill_next = w_kill_sum[KILL_CNT_W-1:0];
    if (w_kill_sum[KILL_CNT_W]) begin
      w_kill_next = {KILL_CNT_W{1'b1}};
    end
  end

  // Pipeline valid bits, EX CSR controls and kill counter, by update priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_v_id        <= 1'b0;
      r_v_ex        <= 1'b0;
      r_csr_enable  <= 1'b0;
      r_csr_op      <= 2'b00;
      r_illegal_csr <= 1'b0;
      r_kill_count  <= '0;
    end else if (w_freeze) begin
      r_v_id <= r_v_id;
    end else if (wrongBranch) begin
      r_v_id        <= 1'b0;
      r_v_ex        <= 1'b0;
      r_csr_enable  <= 1'b0;
      r_csr_op      <= 2'b00;
      r_illegal_csr <= 1'b0;
      r_kill_count  <= w_kill_next;
    end else if (stall) begin
      r_v_ex        <= 1'b0;
      r_csr_enable  <= 1'b0;
      r_csr_op      <= 2'b00;
      r_illegal_csr <= 1'b0;
    end else begin
      r_v_ex        <= r_v_id;
      r_v_id        <= fetch_valid;
      r_csr_enable  <= r_v_id & w_dec_enable;
      r_csr_op      <= r_v_id ? w_dec_op : 2'b00;
      r_illegal_csr <= r_v_id & w_dec_illegal;
    end
  end

  assign ex_valid    = r_v_ex;
  assign retire      = r_v_ex & ~w_freeze;
  assign csr_enable  = r_csr_enable;
  assign csr_op      = r_csr_op;
  assign illegal_csr = r_illegal_csr;
  assign kill_count  = r_kill_count;

endmodule

// File: tb/tb_retire_tracker.sv
// Scoreboard bench for retire_tracker: a slot-level pipeline model predicts
// each cycle's outputs, a monitor compares them against two DUT instances
// (default counter width and a 2-bit counter to reach saturation).
module tb_retire_tracker;

  typedef struct packed {
    logic        ex_valid;
    logic        retire;
    logic        en;
    logic [1:0]  op;
    logic        ill;
    logic [31:0] kc;
    logic [1:0]  kcs;
  } obs_t;

  typedef struct packed {
    logic       en;
    logic [1:0] op;
    logic       ill;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid, IM_stall, DM_stall, stall, wrongBranch;
  logic [31:0] id_inst;

  logic        ex_valid, retire, csr_enable, illegal_csr;
  logic [1:0]  csr_op;
  logic [31:0] kill_count;
  logic        ex_valid_s, retire_s, csr_enable_s, illegal_csr_s;
  logic [1:0]  csr_op_s;
  logic [1:0]  kill_count_s;

  retire_tracker u_dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .IM_stall(IM_stall),
    .DM_stall(DM_stall), .stall(stall), .wrongBranch(wrongBranch),
    .id_inst(id_inst), .ex_valid(ex_valid), .retire(retire),
    .csr_enable(csr_enable), .csr_op(csr_op), .illegal_csr(illegal_csr),
    .kill_count(kill_count)
  );

  retire_tracker #(.KILL_CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .IM_stall(IM_stall),
    .DM_stall(DM_stall), .stall(stall), .wrongBranch(wrongBranch),
    .id_inst(id_inst), .ex_valid(ex_valid_s), .retire(retire_s),
    .csr_enable(csr_enable_s), .csr_op(csr_op_s), .illegal_csr(illegal_csr_s),
    .kill_count(kill_count_s)
  );

  always #5 clk = ~clk;

  obs_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Model: which slots hold an instruction, plus the word that entered EX.
  logic        m_id_full;
  logic        m_ex_full;
  logic [31:0] m_ex_inst;
  longint      m_killed;
  int          m_retired;

  function automatic dec_t decode(input logic [31:0] inst);
    logic [11:0] legal [4];
    dec_t d;
    legal = '{12'hC00, 12'hC80, 12'hC02, 12'hC82};
    d = '0;
    if (inst[6:0] == 7'h73 && inst[14:12] != 3'd0) begin
      d.ill = 1'b1;
      if (inst[14:12] == 3'd2 && inst[19:15] == 5'd0) begin
        for (int i = 0; i < 4; i++) begin
          if (inst[31:20] == legal[i]) begin
            d.en  = 1'b1;
            d.op  = 2'(i);
            d.ill = 1'b0;
          end
        end
      end
    end
    return d;
  endfunction

  task automatic model_reset();
    m_id_full = 1'b0;
    m_ex_full = 1'b0;
    m_ex_inst = '0;
    m_killed  = 0;
  endtask

  // Apply one cycle of inputs, predict its outputs, then advance the model.
  task automatic cyc(input logic fv, input logic ims, input logic dms,
                     input logic st, input logic wb, input logic [31:0] inst,
                     input logic rv);
    obs_t e;
    dec_t d;
    fetch_valid = fv; IM_stall = ims; DM_stall = dms;
    stall = st; wrongBranch = wb; id_inst = inst; rst = rv;
    d = m_ex_full ? decode(m_ex_inst) : '0;
    e.ex_valid = m_ex_full;
    e.retire   = m_ex_full && !(ims || dms);
    e.en       = d.en;
    e.op       = d.op;
    e.ill      = d.ill;
    e.kc       = (m_killed > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_killed);
    e.kcs      = (m_killed > 3) ? 2'd3 : 2'(m_killed);
    sb.push_back(e);
    if (e.retire) m_retired++;
    @(posedge clk);
    if (!rv) begin
      model_reset();
    end else if (ims || dms) begin
      // pipeline frozen
    end else if (wb) begin
      m_killed  = m_killed + longint'(m_id_full) + longint'(fv);
      m_id_full = 1'b0;
      m_ex_full = 1'b0;
    end else if (st) begin
      m_ex_full = 1'b0;
    end else begin
      m_ex_full = m_id_full;
      m_ex_inst = m_id_full ? inst : 32'h0;
      m_id_full = fv;
    end
    #1;
  endtask

  // Monitor: compare each predicted cycle against both DUT instances.
  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = '{ex_valid, retire, csr_enable, csr_op, illegal_csr, kill_count, kill_count_s};
      vectors++;
      if (a !== e || {ex_valid_s, retire_s, csr_enable_s, csr_op_s, illegal_csr_s}
                     !== {e.ex_valid, e.retire, e.en, e.op, e.ill}) begin
        miscompares++;
        $display("FAIL cycle_outputs t=%0t got ev=%b ret=%b en=%b op=%0d ill=%b kc=%0d kcs=%0d (sat: ev=%b ret=%b en=%b op=%0d ill=%b) exp ev=%b ret=%b en=%b op=%0d ill=%b kc=%0d kcs=%0d",
                 $time, a.ex_valid, a.retire, a.en, a.op, a.ill, a.kc, a.kcs,
                 ex_valid_s, retire_s, csr_enable_s, csr_op_s, illegal_csr_s,
                 e.ex_valid, e.retire, e.en, e.op, e.ill, e.kc, e.kcs);
      end
    end
  end

  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] pool [10];

  initial begin
    int r;
    int wait_cycles;
    pool = '{32'hC000_2573, 32'hC800_2573, 32'hC020_2573, 32'hC820_2573,
             32'h3000_2573, 32'hC001_2573, 32'hC000_1573, 32'h0000_0073,
             32'h0010_0073, 32'h00B5_0533};
    m_retired = 0;
    model_reset();
    {fetch_valid, IM_stall, DM_stall, stall, wrongBranch} = '0;
    id_inst = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, NOP, 0);

    // Straight line: 10 fetches, 10 pulses starting two cycles later.
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, NOP, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, NOP, 1);

    // Freeze mid-stream with a CSR read sitting in EX.
    cyc(1, 0, 0, 0, 0, NOP, 1);
    cyc(1, 0, 0, 0, 0, 32'hC820_2573, 1);
    repeat (3) cyc(1, 0, 1, 0, 0, NOP, 1);
    cyc(1, 0, 0, 0, 0, 32'h3000_2573, 1);
    repeat (2) cyc(0, 0, 0, 0, 0, NOP, 1);

    // Mispredict with ID and fetch valid, then saturate the narrow counter.
    repeat (2) cyc(1, 0, 0, 0, 0, NOP, 1);
    cyc(1, 0, 0, 0, 1, NOP, 1);
    repeat (2) cyc(0, 0, 0, 0, 0, NOP, 1);
    repeat (2) cyc(1, 0, 0, 0, 0, NOP, 1);
    cyc(1, 0, 0, 0, 1, NOP, 1);
    cyc(1, 0, 0, 0, 1, NOP, 1);
    // Frozen wrongBranch must not count.
    cyc(1, 1, 0, 0, 1, NOP, 1);

    // Load-use stall, and stall together with wrongBranch.
    repeat (2) cyc(1, 0, 0, 0, 0, NOP, 1);
    cyc(1, 0, 0, 1, 0, 32'hC000_2573, 1);
    repeat (2) cyc(1, 0, 0, 0, 0, 32'hC000_2573, 1);
    cyc(1, 0, 0, 1, 1, NOP, 1);
    repeat (2) cyc(0, 0, 0, 0, 0, NOP, 1);

    // Reset mid-stream while EX is valid.
    repeat (3) cyc(1, 0, 0, 0, 0, 32'hC002_2573, 1);
    cyc(1, 0, 0, 0, 0, NOP, 0);
    repeat (3) cyc(1, 0, 0, 0, 0, NOP, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      cyc(($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 8)  ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 8)  ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < 8)  ? 1'b1 : 1'b0,
          (r < 80) ? pool[$urandom_range(0, 9)] : $urandom,
          ($urandom_range(0, 99) < 2)  ? 1'b0 : 1'b1);
    end
    {fetch_valid, IM_stall, DM_stall, stall, wrongBranch} = '0;

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d predicted cycles never checked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
